// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: one bit per cycle, first bit one cycle after the handshake, then GAP_CYCLES idle cycles.
// data_ready is high only in IDLE, so upstream must hold the word until it is accepted.
module bit_serializer #(
  parameter int unsigned DATA_W     = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ser_bit,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned     CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [3:0]      GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [CNT_W-1:0]    bit_cnt_q;
  logic [3:0]          gap_cnt_q;
  logic [DATA_W-1:0]   shreg_d;
  logic                head_bit;

  assign head_bit = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];
  assign shreg_d  = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (data_valid) begin
            shreg_q   <= data_in;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_d;
          if (bit_cnt_q == BIT_LAST) begin
            gap_cnt_q <= '0;
            state_q   <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q + 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // data_ready is also gated by rst so it reads 0 while reset is held.
  assign data_ready = rst && (state_q == IDLE);
  assign bit_valid  = (state_q == SHIFT);
  assign ser_bit    = bit_valid && head_bit;
  assign busy       = (state_q != IDLE);
  assign done       = bit_valid && (bit_cnt_q == BIT_LAST);

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (MSB/gap2, LSB/gap2, MSB/gap0) share stimulus; one is observed at a time.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic [2:0] rdy_w, ser_w, vld_w, busy_w, done_w;
  logic [1:0] sel = 2'd0;
  logic [4:0] obs;
  int         vectors = 0;
  int         errors = 0;
  bit         exp_q[$];

  always #5 clk = ~clk;

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(2)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_w[0]), .ser_bit(ser_w[0]), .bit_valid(vld_w[0]),
    .busy(busy_w[0]), .done(done_w[0]));

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) u_lsb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_w[1]), .ser_bit(ser_w[1]), .bit_valid(vld_w[1]),
    .busy(busy_w[1]), .done(done_w[1]));

  bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(rdy_w[2]), .ser_bit(ser_w[2]), .bit_valid(vld_w[2]),
    .busy(busy_w[2]), .done(done_w[2]));

  // Observed tuple: {bit_valid, ser_bit, done, data_ready, busy}
  assign obs = {vld_w[sel], ser_w[sel], done_w[sel], rdy_w[sel], busy_w[sel]};

  // Reference Mealy detector for 1011 (overlapping), fed by the MSB-first instance.
  logic [2:0] hist_q;
  logic       det_dout;
  assign det_dout = vld_w[0] && ({hist_q, ser_w[0]} == 4'b1011);
  always @(posedge clk or negedge rst) begin
    if (!rst)            hist_q <= 3'b000;
    else if (!busy_w[0]) hist_q <= 3'b000;
    else if (vld_w[0])   hist_q <= {hist_q[1:0], ser_w[0]};
  end

  task automatic push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++) exp_q.push_back(msb ? w[7-i] : w[i]);
  endtask

  task automatic test_reset;
    #3;
    vectors++;
    if ({vld_w, ser_w, done_w, rdy_w, busy_w} !== 15'b0) begin
      errors++;
      $display("FAIL reset_hold got=%b want=0", {vld_w, ser_w, done_w, rdy_w, busy_w});
    end
    @(negedge clk);
    vectors++;
    if ({vld_w, ser_w, done_w, rdy_w, busy_w} !== 15'b0) begin
      errors++;
      $display("FAIL reset_after_edge got=%b want=0", {vld_w, ser_w, done_w, rdy_w, busy_w});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({rdy_w, busy_w, vld_w} !== 9'b111_000_000) begin
      errors++;
      $display("FAIL reset_release got=%b want=111000000", {rdy_w, busy_w, vld_w});
    end
  endtask

  // Single word on a gap-2 instance: 8 bits, 2 gap cycles, IDLE on cycle 11.
  task automatic test_single(input logic [1:0] s, input logic [7:0] w, input bit msb);
    logic [4:0] exp_v;
    bit         eb;
    sel = s;
    exp_q.delete();
    push_word(w, msb);
    @(negedge clk);
    data_in = w;
    data_valid = 1'b1;
    vectors++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL single_pre got=%b want=00010", obs);
    end
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      data_valid = 1'b0;
      eb = 1'b0;
      if (c <= 8 && exp_q.size() > 0) eb = exp_q.pop_front();
      exp_v = {c <= 8, eb, c == 8, c == 11, c <= 10};
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL single sel=%0d cycle=%0d got=%b want=%b", s, c, obs, exp_v);
      end
    end
  endtask

  // GAP=0 with data_valid held: FF, one IDLE cycle, then 00.
  task automatic test_back_to_back;
    logic [4:0] exp_v;
    bit         eb;
    sel = 2'd2;
    exp_q.delete();
    push_word(8'hFF, 1'b1);
    push_word(8'h00, 1'b1);
    @(negedge clk);
    data_in = 8'hFF;
    data_valid = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      data_in = 8'h00;
      if (c >= 10) data_valid = 1'b0;
      eb = 1'b0;
      if (c != 9 && c != 18 && exp_q.size() > 0) eb = exp_q.pop_front();
      exp_v = {c != 9 && c != 18, eb, c == 8 || c == 17, c == 9 || c == 18, c != 9 && c != 18};
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL back_to_back cycle=%0d got=%b want=%b", c, obs, exp_v);
      end
    end
  endtask

  // 55 presented during the A0 shift must wait for the next IDLE cycle.
  task automatic test_ignored_request;
    logic [4:0] exp_v;
    bit         eb;
    bit         shifting;
    sel = 2'd0;
    exp_q.delete();
    push_word(8'hA0, 1'b1);
    push_word(8'h55, 1'b1);
    @(negedge clk);
    data_in = 8'hA0;
    data_valid = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      data_in = 8'h55;
      if (c >= 12) data_valid = 1'b0;
      shifting = (c <= 8) || (c >= 12 && c <= 19);
      eb = 1'b0;
      if (shifting && exp_q.size() > 0) eb = exp_q.pop_front();
      exp_v = {shifting, eb, c == 8 || c == 19, c == 11 || c == 22, c != 11 && c != 22};
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL ignored_req cycle=%0d got=%b want=%b", c, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [4:0] exp_v;
    bit         eb;
    sel = 2'd0;
    exp_q.delete();
    push_word(8'hC3, 1'b1);
    @(negedge clk);
    data_in = 8'hC3;
    data_valid = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      data_valid = 1'b0;
      eb = exp_q.pop_front();
      exp_v = {1'b1, eb, 1'b0, 1'b0, 1'b1};
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mid_pre cycle=%0d got=%b want=%b", c, obs, exp_v);
      end
    end
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({vld_w, ser_w, done_w, rdy_w, busy_w} !== 15'b0) begin
      errors++;
      $display("FAIL mid_async got=%b want=0", {vld_w, ser_w, done_w, rdy_w, busy_w});
    end
    @(negedge clk);
    vectors++;
    if ({vld_w, ser_w, done_w, rdy_w, busy_w} !== 15'b0) begin
      errors++;
      $display("FAIL mid_held got=%b want=0", {vld_w, ser_w, done_w, rdy_w, busy_w});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== 5'b00010) begin
      errors++;
      $display("FAIL mid_release got=%b want=00010", obs);
    end
    exp_q.delete();
    push_word(8'h81, 1'b1);
    data_in = 8'h81;
    data_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      data_valid = 1'b0;
      eb = 1'b0;
      if (c <= 8 && exp_q.size() > 0) eb = exp_q.pop_front();
      exp_v = {c <= 8, eb, c == 8, c == 11, c <= 10};
      vectors++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mid_after cycle=%0d got=%b want=%b", c, obs, exp_v);
      end
    end
  endtask

  // B6 = 1,0,1,1,0,1,1,0 contains 1011 ending at bits 4 and 7.
  task automatic test_detector;
    sel = 2'd0;
    @(negedge clk);
    data_in = 8'hB6;
    data_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      data_valid = 1'b0;
      vectors++;
      if (det_dout !== (c == 4 || c == 7)) begin
        errors++;
        $display("FAIL detector cycle=%0d got=%b want=%b", c, det_dout, (c == 4 || c == 7));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(2'd0, 8'hB4, 1'b1);
    test_single(2'd1, 8'h0D, 1'b0);
    test_back_to_back();
    test_ignored_request();
    test_reset_mid();
    test_detector();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 shifts bit DATA_W-1 first, 0 shifts bit 0 first.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 2, giving the idle-level cycles inserted after each word (legal range 0..15).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assertion, active-low.
REQ-006 data_in  input  DATA_W  parallel word to serialize; sampled only on handshake.
REQ-007 data_valid  input  1  upstream word available.
REQ-008 data_ready  output  1  block can accept a word this cycle.
REQ-009 ser_bit  output  1  serial bit stream; drives the din_bit input of the downstream Mealy sequence detector.
REQ-010 bit_valid  output  1  ser_bit carries a data bit this cycle.
REQ-011 busy  output  1  state is not IDLE.
REQ-012 done  output  1  one-cycle pulse marking the last bit of a word.

Function
REQ-013 The FSM SHALL have three states, IDLE, SHIFT and GAP, with IDLE as the reset state.
REQ-014 data_ready SHALL be 1 in IDLE and 0 in SHIFT and GAP; it is combinational from state only.
REQ-015 Handshake: when data_valid=1 and data_ready=1 at a rising edge, the block SHALL capture data_in into the shift register, clear bit_cnt to 0, and move to SHIFT.
REQ-016 data_valid while data_ready=0 SHALL be ignored; the upstream holds data_in and data_valid until accepted.
REQ-017 In SHIFT, ser_bit SHALL be the current output bit of the shift register: its MSB if MSB_FIRST=1, its LSB otherwise.
REQ-018 In SHIFT, bit_valid SHALL be 1; each rising edge SHALL shift the register by one and increment bit_cnt.
REQ-019 Latency: the first data bit SHALL appear on ser_bit in the first cycle after the handshake edge, and each bit SHALL be held exactly one cycle.
REQ-020 done SHALL be 1 exactly while bit_cnt = DATA_W-1 in SHIFT.
REQ-021 At the edge ending that cycle, the FSM SHALL go to GAP if GAP_CYCLES>0, otherwise to IDLE.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, counted by gap_cnt, then return to IDLE.
REQ-023 In IDLE and GAP, ser_bit SHALL be 0 and bit_valid SHALL be 0.
REQ-024 Minimum word period SHALL be DATA_W+GAP_CYCLES+1 cycles: one IDLE cycle always separates words, even with GAP_CYCLES=0 and data_valid held high.
REQ-025 bit_cnt SHALL be ceil(log2(DATA_W)) bits wide, and gap_cnt SHALL be 4 bits wide.
REQ-026 Neither counter SHALL wrap: bit_cnt is never incremented past DATA_W-1, and gap_cnt is never incremented past GAP_CYCLES-1.
REQ-027 Any state encoding not in {IDLE, SHIFT, GAP} SHALL transition to IDLE on the next edge.

Reset
REQ-028 While rst=0, the outputs SHALL be data_ready=0, ser_bit=0, bit_valid=0, busy=0 and done=0.
REQ-029 While rst=0, state SHALL be IDLE and the shift register and both counters SHALL be 0.
REQ-030 Reset assertion mid-word SHALL take effect immediately, without waiting for clk, and the partial word SHALL be discarded with no done pulse.
REQ-031 After rst returns to 1, data_ready SHALL be 1 from the first cycle, and the first handshake SHALL be accepted at the first rising edge.

Verification
REQ-032 Reset then single word: DATA_W=8, MSB_FIRST=1, GAP=2, data_in=8'hB4 handshaked once -> ser_bit 1,0,1,1,0,1,0,0 on cycles 1..8 after handshake, done high on cycle 8 only, ser_bit=0 on cycles 9-10, data_ready=1 on cycle 11.
REQ-033 LSB-first: MSB_FIRST=0, data_in=8'h0D -> ser_bit 1,0,1,1,0,0,0,0; bit_valid high for exactly 8 cycles.
REQ-034 Back-to-back, GAP=0: data_valid held high with 8'hFF then 8'h00 -> 8 ones, one IDLE cycle (ser_bit=0, bit_valid=0), 8 zeros; data_ready high only in the IDLE cycles.
REQ-035 Ignored request: data_in changed to 8'h55 with data_valid=1 during SHIFT of 8'hA0 -> stream remains 1,0,1,0,0,0,0,0, and 8'h55 is taken only at the next IDLE.
REQ-036 Reset mid-operation: rst=0 asserted between clk edges after the 3rd bit -> all outputs 0 immediately with no done pulse, and after release a new word 8'h81 serializes correctly.
REQ-037 Downstream check: output connected to the Mealy detector with a word containing its target pattern -> the detector's dout_bit pulses at the expected bit positions.
